// File: rtl/frame_compositor.sv
// frame_compositor
//
// Draws one frame per accepted start request: streams the whole background
// image from the background memory to the VGA adapter, then overlays a sprite
// box read from a sprite ROM at a position latched when the request was taken.
// One pixel slot per clock with no gaps between the background and the sprite.
//
// Handshake: iStart is a single-cycle request with no ready signal. It is
// accepted only when the FSM is IDLE and oDone is low. Requests seen at any
// other time are dropped, not queued. oBusy is the "request in progress"
// indication, and oDone is the one-cycle completion pulse.
//
// Ports
//   iClock, iResetn      clock, asynchronous active-low reset
//   iStart               frame request (see handshake above)
//   iSpriteX, iSpriteY   sprite top-left corner, sampled on acceptance
//   oBgAddr, iBgData     background memory port ({y,x}), 1-cycle read latency
//   oSprAddr, iSprData   sprite ROM port (row*SPR_W+col), 1-cycle read latency
//   oX, oY, oColour      pixel to the VGA adapter
//   oPlot                adapter write enable
//   oBusy, oDone         frame in progress / frame complete pulse
//   oDbgState            current FSM state (IDLE=0, BG=1, SPR=2, DONE=3)
module frame_compositor #(
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter int          SPR_W    = 16,
  parameter int          SPR_H    = 16,
  parameter int          SPR_AW   = 8,
  parameter logic [2:0]  TRANSP   = 3'b101
) (
  input  logic              iClock,
  input  logic              iResetn,
  input  logic              iStart,
  input  logic [7:0]        iSpriteX,
  input  logic [6:0]        iSpriteY,
  output logic [14:0]       oBgAddr,
  input  logic [2:0]        iBgData,
  output logic [SPR_AW-1:0] oSprAddr,
  input  logic [2:0]        iSprData,
  output logic [7:0]        oX,
  output logic [6:0]        oY,
  output logic [2:0]        oColour,
  output logic              oPlot,
  output logic              oBusy,
  output logic              oDone,
  output logic [1:0]        oDbgState
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  localparam logic [7:0]    X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]    Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(SPR_H - 1);
  localparam logic [8:0]    X_LIM  = 9'(SCREEN_W);
  localparam logic [7:0]    Y_LIM  = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BG   = 2'd1,
    S_SPR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched sprite position
  logic [7:0] lat_x;
  logic [6:0] lat_y;

  // Issue counters
  logic [7:0]        bg_x;
  logic [6:0]        bg_y;
  logic [CW-1:0]     spr_col;
  logic [RW-1:0]     spr_row;
  logic [SPR_AW-1:0] spr_addr;
  // Set once the last sprite address has been issued; the SPR state then
  // waits one slot so DONE lines up with the last pixel being presented.
  logic              spr_end;

  // Issue stage: the coordinate that goes with the address currently on the
  // memory ports. Present stage: the same, one clock later, aligned with the
  // returned data.
  logic       iss_v, iss_spr;
  logic [8:0] iss_x;
  logic [7:0] iss_y;
  logic       pix_v, pix_spr;
  logic [8:0] pix_x;
  logic [7:0] pix_y;

  logic       start_ok;
  logic       bg_issue, spr_issue;
  logic       bg_last, spr_last;
  logic [8:0] spr_x;
  logic [7:0] spr_y;

  assign start_ok  = (state == S_IDLE) && iStart && !oDone;
  assign bg_last   = (bg_x == X_LAST) && (bg_y == Y_LAST);
  assign spr_last  = (spr_col == C_LAST) && (spr_row == R_LAST);
  // Unwrapped sprite screen coordinate; the extra top bit keeps off-screen
  // pixels from folding back onto the left/top edge.
  assign spr_x     = {1'b0, lat_x} + 9'(spr_col);
  assign spr_y     = {1'b0, lat_y} + 8'(spr_row);
  assign oDbgState = state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bg_issue  = 1'b0;
    spr_issue = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_BG;
      S_BG: begin
        bg_issue = 1'b1;
        if (bg_last) state_nxt = S_SPR;
      end
      S_SPR: begin
        if (spr_end) state_nxt = S_DONE;
        else         spr_issue = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- counters / addresses
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      lat_x    <= '0;
      lat_y    <= '0;
      bg_x     <= '0;
      bg_y     <= '0;
      spr_col  <= '0;
      spr_row  <= '0;
      spr_addr <= '0;
      spr_end  <= 1'b0;
      oBgAddr  <= '0;
      oSprAddr <= '0;
    end else begin
      if (start_ok) begin
        lat_x    <= iSpriteX;
        lat_y    <= iSpriteY;
        bg_x     <= '0;
        bg_y     <= '0;
        spr_col  <= '0;
        spr_row  <= '0;
        spr_addr <= '0;
        spr_end  <= 1'b0;
      end
      if (bg_issue) begin
        oBgAddr <= {bg_y, bg_x};
        if (bg_x == X_LAST) begin
          bg_x <= '0;
          bg_y <= (bg_y == Y_LAST) ? 7'd0 : bg_y + 7'd1;
        end else begin
          bg_x <= bg_x + 8'd1;
        end
      end
      if (spr_issue) begin
        oSprAddr <= spr_addr;
        spr_addr <= spr_addr + 1'b1;
        if (spr_col == C_LAST) begin
          spr_col <= '0;
          spr_row <= spr_row + 1'b1;
        end else begin
          spr_col <= spr_col + 1'b1;
        end
        if (spr_last) spr_end <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------ pixel pipeline
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      iss_v   <= 1'b0;
      iss_spr <= 1'b0;
      iss_x   <= '0;
      iss_y   <= '0;
      pix_v   <= 1'b0;
      pix_spr <= 1'b0;
      pix_x   <= '0;
      pix_y   <= '0;
    end else begin
      iss_v   <= bg_issue | spr_issue;
      iss_spr <= spr_issue;
      if (bg_issue) begin
        iss_x <= {1'b0, bg_x};
        iss_y <= {1'b0, bg_y};
      end else if (spr_issue) begin
        iss_x <= spr_x;
        iss_y <= spr_y;
      end
      pix_v   <= iss_v;
      pix_spr <= iss_spr;
      pix_x   <= iss_x;
      pix_y   <= iss_y;
    end
  end

  // Returned memory data is combined with the present stage directly, so a
  // slot issued in cycle n is presented in cycle n+1.
  always_comb begin
    oX      = pix_x[7:0];
    oY      = pix_y[6:0];
    oColour = 3'd0;
    oPlot   = 1'b0;
    if (pix_v) begin
      if (pix_spr) begin
        oColour = iSprData;
        oPlot   = (iSprData != TRANSP) && (pix_x < X_LIM) && (pix_y < Y_LIM);
      end else begin
        oColour = iBgData;
        oPlot   = 1'b1;
      end
    end
  end

  // ------------------------------------------------------ busy / done
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= (state == S_DONE);
      if (start_ok)              oBusy <= 1'b1;
      else if (state == S_DONE)  oBusy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_compositor.sv
module tb_frame_compositor;

  localparam int         W      = 160;
  localparam int         H      = 30;
  localparam int         SW     = 16;
  localparam int         SH     = 16;
  localparam logic [2:0] TRANSP = 3'b101;
  // Edges from the accepting edge to the edge after which oDone is high.
  localparam int         DONE_LAT = W * H + SW * SH + 2;

  logic        iClock, iResetn, iStart;
  logic [7:0]  iSpriteX;
  logic [6:0]  iSpriteY;
  logic [14:0] oBgAddr;
  logic [2:0]  iBgData;
  logic [7:0]  oSprAddr;
  logic [2:0]  iSprData;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot, oBusy, oDone;
  logic [1:0]  oDbgState;

  frame_compositor #(
    .SCREEN_W(W), .SCREEN_H(H), .SPR_W(SW), .SPR_H(SH), .SPR_AW(8), .TRANSP(TRANSP)
  ) dut (
    .iClock(iClock), .iResetn(iResetn), .iStart(iStart),
    .iSpriteX(iSpriteX), .iSpriteY(iSpriteY),
    .oBgAddr(oBgAddr), .iBgData(iBgData),
    .oSprAddr(oSprAddr), .iSprData(iSprData),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .oBusy(oBusy), .oDone(oDone), .oDbgState(oDbgState)
  );

  // ---------------------------------------------------- clock / reset
  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int edge_n = 0;
  always @(posedge iClock) edge_n++;

  // ---------------------------------------------------- memory models
  int         spr_mode = 0;  // 0 transparent, 1 col index, 2 opaque, 3 random
  logic [2:0] spr_tab [256];

  function automatic logic [2:0] bg_col(input logic [14:0] a);
    return a[2:0] ^ a[10:8] ^ a[13:11];
  endfunction

  function automatic logic [2:0] spr_rom(input logic [7:0] a);
    case (spr_mode)
      0:       return TRANSP;
      1:       return a[2:0];
      2:       return 3'b010;
      default: return spr_tab[a];
    endcase
  endfunction

  always @(posedge iClock) begin
    iBgData  <= bg_col(oBgAddr);
    iSprData <= spr_rom(oSprAddr);
  end

  // ---------------------------------------------------- scoreboard
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int plots_seen = 0;
  int first_plot_edge = -1;
  bit first_pending = 0;
  int done_count = 0;
  int start_edge = 0;
  int done_at = 0;
  bit saw_clip160 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge iClock) begin
    if (iResetn) begin
      if (oDone) done_count++;
      if (oBusy && !oPlot && oX == 8'd160 && oY == 7'd22) saw_clip160 = 1;
      if (oPlot) begin
        plots_seen++;
        if (first_pending) begin
          first_plot_edge = edge_n;
          first_pending = 0;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL plot_unexpected: got (%0d,%0d) c=%0d expected no plot",
                   oX, oY, oColour);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({oX, oY, oColour} !== e) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d",
                     oX, oY, oColour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end
    end
  end

  // Pushes every pixel the adapter should receive for one frame, in order.
  task automatic push_frame(input int sx, input int sy, output int n);
    n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [7:0] xb;
        logic [6:0] yb;
        xb = 8'(x);
        yb = 7'(y);
        exp_q.push_back({xb, yb, bg_col({yb, xb})});
        n++;
      end
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        int x, y;
        logic [2:0] col;
        x = sx + c;
        y = sy + r;
        col = spr_rom(8'(r * SW + c));
        if (col != TRANSP && x < W && y < H) begin
          exp_q.push_back({8'(x), 7'(y), col});
          n++;
        end
      end
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic start_frame(input logic [7:0] sx, input logic [6:0] sy, output int n);
    @(negedge iClock);
    iSpriteX = sx;
    iSpriteY = sy;
    iStart = 1'b1;
    push_frame(int'(sx), int'(sy), n);
    plots_seen = 0;
    first_plot_edge = -1;
    first_pending = 1;
    start_edge = edge_n + 1;
    @(negedge iClock);
    iStart = 1'b0;
    chk("busy_after_start", int'(oBusy), 1);
  endtask

  // Returns at the negedge where oDone is first seen high.
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < DONE_LAT + 100; i++) begin
      @(negedge iClock);
      if (oDone) begin
        ok = 1;
        done_at = edge_n;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no oDone expected oDone within %0d cycles", DONE_LAT + 100);
    end
  endtask

  task automatic end_frame(input string tag, input int n_exp);
    chk({tag, "_done_latency"}, done_at - start_edge, DONE_LAT);
    chk({tag, "_first_plot_latency"}, first_plot_edge - start_edge, 2);
    chk({tag, "_plot_count"}, plots_seen, n_exp);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_busy_at_done"}, int'(oBusy), 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] sx, input logic [6:0] sy,
                           input int mode, input int tab_exp);
    int n;
    bit ok;
    spr_mode = mode;
    start_frame(sx, sy, n);
    wait_done(ok);
    if (ok) end_frame(tag, (tab_exp < 0) ? n : tab_exp);
    exp_q.delete();
  endtask

  // ---------------------------------------------------- vectors
  typedef struct {
    logic [7:0] sx;
    logic [6:0] sy;
    int         mode;
    int         exp_plots;   // -1: use the model's count
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int d0;
    bit ok;

    for (int i = 0; i < 256; i++) spr_tab[i] = 3'($urandom_range(0, 7));
    vecs[0] = '{8'd0,   7'd0,   0, W * H};        // sprite fully transparent
    vecs[1] = '{8'd10,  7'd5,   1, W * H + 224};  // cols 5 and 13 transparent
    vecs[2] = '{8'd150, 7'd22,  2, W * H + 80};   // clipped right and bottom
    vecs[3] = '{8'd250, 7'd125, 2, W * H};        // entirely off-screen, no wrap
    vecs[4] = '{8'($urandom_range(0, W - 1)), 7'($urandom_range(0, H - 1)), 3, -1};

    iResetn = 1'b0;
    iStart = 1'b0;
    iSpriteX = '0;
    iSpriteY = '0;
    repeat (3) @(negedge iClock);
    chk("reset_plot", int'(oPlot), 0);
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_done", int'(oDone), 0);
    chk("reset_state", int'(oDbgState), 0);
    chk("reset_bgaddr", int'(oBgAddr), 0);
    iResetn = 1'b1;
    repeat (3) @(negedge iClock);

    // Table-driven frames, each started the cycle after the previous oDone.
    for (int i = 0; i < 5; i++) begin
      saw_clip160 = 0;
      run_frame($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].mode, vecs[i].exp_plots);
      if (i == 2) chk("clip_slot_x160_shown", int'(saw_clip160), 1);
    end

    // Starts during the frame and coinciding with oDone are dropped.
    repeat (5) @(negedge iClock);
    spr_mode = 0;
    start_frame(8'd0, 7'd0, n);
    d0 = done_count;
    repeat (2998) @(negedge iClock);
    iSpriteX = 8'd77;
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    wait_done(ok);
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    chk("ignored_state_after_done", int'(oDbgState), 0);
    repeat (50) @(negedge iClock);
    if (ok) end_frame("ignored", n);
    chk("ignored_one_done", done_count - d0, 1);
    chk("ignored_no_restart_busy", int'(oBusy), 0);
    exp_q.delete();

    // Asynchronous reset in the middle of a frame.
    spr_mode = 1;
    start_frame(8'd5, 7'd5, n);
    repeat (2999) @(negedge iClock);
    iResetn = 1'b0;
    #1;
    chk("midreset_plot", int'(oPlot), 0);
    chk("midreset_busy", int'(oBusy), 0);
    chk("midreset_done", int'(oDone), 0);
    chk("midreset_state", int'(oDbgState), 0);
    exp_q.delete();
    @(negedge iClock);
    iResetn = 1'b1;
    plots_seen = 0;
    repeat (50) @(negedge iClock);
    chk("post_reset_no_plots", plots_seen, 0);
    chk("post_reset_busy", int'(oBusy), 0);
    run_frame("after_reset", 8'd5, 7'd5, 1, W * H + 224);

    // Back-to-back with a new sprite position.
    run_frame("b2b", 8'd100, 7'd10, 2, W * H + 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
